pcs_hss_fault_sched: RTL and testbench

Programmable fault-injection scheduler inserted in the PCS→HSS transmit path of the fake-HSS testbench. It replaces free-running `$random` injection with deterministic, countable events. After accepting a configuration it passes PCS words through with one cycle of latency. It corrupts chosen words, either by flipping bits or by dropping them to zero, at a programmed word spacing with optional LFSR jitter, then reports completion and event counts to the bench scoreboard.

---
 rtl/pcs_tb_pkg.sv | 31 +++
 rtl/pcs_lfsr20.sv | 24 ++
 rtl/pcs_hss_fault_sched.sv | 163 ++++++++++++++++
 tb/tb_pcs_hss_fault_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_tb_pkg.sv
// Shared definitions for the PCS->HSS interferer blocks of the fake-HSS bench.
// Holds the fault-mode and scheduler state encodings, the LFSR tap constant
// and the bit-error flip-mask rule. Other interferers reuse the flip mask so
// that all of them corrupt the same bits.
package pcs_tb_pkg;

  typedef enum logic [1:0] {
    FM_NONE   = 2'b00,
    FM_BITERR = 2'b01,
    FM_LOST   = 2'b10,
    FM_ALT    = 2'b11
  } fault_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_INJECT = 2'd2
  } fsched_state_t;

  // Fibonacci taps 20 and 17 (bits 19 and 16).
  localparam logic [19:0] LFSR20_TAPS = 20'h90000;

  // Widest datapath the flip-mask helper supports.
  localparam int FLIP_MAXW = 256;

  // Bit-error rule: invert the MSB and the two LSBs of the word.
  function automatic logic [FLIP_MAXW-1:0] biterr_flip_mask(input int unsigned dw);
    return (FLIP_MAXW'(1) << (dw - 1)) | FLIP_MAXW'(3);
  endfunction

endpackage

// File: rtl/pcs_lfsr20.sv
// 20-bit Fibonacci LFSR used as the jitter source of the fault scheduler.
// Advances on every clock that is not in reset.
// Ports:
//   clk   in   clock
//   Rst   in   synchronous active-high reset, loads SEED
//   lfsr  out  current 20-bit state
module pcs_lfsr20 #(
  parameter logic [19:0] SEED = 20'h5A5A5
) (
  input  logic        clk,
  input  logic        Rst,
  output logic [19:0] lfsr
);
  import pcs_tb_pkg::*;

  always_ff @(posedge clk) begin
    if (Rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[18:0], ^(lfsr & LFSR20_TAPS)};
    end
  end

endmodule

// File: rtl/pcs_hss_fault_sched.sv
// Programmable fault-injection scheduler for the PCS->HSS transmit path.
// Words pass with one cycle of latency. After a configuration is accepted,
// every (gap+1)th valid word (plus optional LFSR jitter) is corrupted by a bit
// flip or dropped to zero, for a programmed number of events.
// Ports:
//   clk, Rst                      clock, synchronous active-high reset
//   cfg_valid/cfg_ready           configuration handshake
//   cfg_mode/gap/jmask/burst      fault type, spacing, jitter mask, event count
//   abort                         end the current run
//   din/din_valid                 PCS word in
//   dout/dout_valid               word to the HSS (registered)
//   busy, done                    run active, one-cycle end-of-run pulse
//   err_cnt, lost_cnt             saturating event counters since reset
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | pass-through, waiting for a configuration
// ST_GAP    | counting clean valid words down to the next event
// ST_INJECT | next valid word is the fault word
module pcs_hss_fault_sched #(
  parameter int          DW        = 64,
  parameter int          CW        = 16,
  parameter logic [19:0] LFSR_SEED = 20'h5A5A5
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_mode,
  input  logic [CW-1:0] cfg_gap,
  input  logic [CW-1:0] cfg_jmask,
  input  logic [7:0]    cfg_burst,
  input  logic          abort,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_cnt,
  output logic [15:0]   lost_cnt
);
  import pcs_tb_pkg::*;

  localparam logic [FLIP_MAXW-1:0] FLIP_FULL = biterr_flip_mask(DW);
  localparam logic [DW-1:0]        FLIP      = FLIP_FULL[DW-1:0];

  fsched_state_t state;
  fault_mode_t   mode_q;
  logic [CW-1:0] gap_q;
  logic [CW-1:0] jmask_q;
  logic [CW-1:0] gap_cnt;
  logic [7:0]    burst_rem;
  logic          burst_inf;
  logic          cur_lost;

  logic [19:0]   lfsr;
  logic [CW-1:0] jitter_src;
  logic [CW-1:0] cfg_gap_eff;
  logic [CW-1:0] load_first;
  logic [CW-1:0] load_next;

  pcs_lfsr20 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .Rst  (Rst),
    .lfsr (lfsr)
  );

  assign jitter_src  = CW'(lfsr);
  assign cfg_gap_eff = (cfg_gap == '0) ? CW'(1) : cfg_gap;
  // Sums are truncated to CW bits.
  assign load_first  = cfg_gap_eff + (jitter_src & cfg_jmask);
  assign load_next   = gap_q + (jitter_src & jmask_q);

  always_ff @(posedge clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      mode_q     <= FM_NONE;
      gap_q      <= '0;
      jmask_q    <= '0;
      gap_cnt    <= '0;
      burst_rem  <= '0;
      burst_inf  <= 1'b0;
      cur_lost   <= 1'b0;
      cfg_ready  <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      lost_cnt   <= '0;
    end else begin
      dout       <= din;
      dout_valid <= din_valid;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          // cfg_ready stays low for the first IDLE cycle after a run ends.
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            mode_q    <= fault_mode_t'(cfg_mode);
            gap_q     <= cfg_gap_eff;
            jmask_q   <= cfg_jmask;
            burst_rem <= cfg_burst;
            burst_inf <= (cfg_burst == 8'd0);
            cur_lost  <= (fault_mode_t'(cfg_mode) == FM_LOST);
            gap_cnt   <= load_first;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          cfg_ready <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (din_valid) begin
            if (gap_cnt == CW'(1)) begin
              state <= ST_INJECT;
            end else begin
              gap_cnt <= gap_cnt - CW'(1);
            end
          end
        end
        ST_INJECT: begin
          cfg_ready <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (din_valid) begin
            if (mode_q != FM_NONE) begin
              if (cur_lost) begin
                dout <= '0;
                if (lost_cnt != 16'hFFFF) lost_cnt <= lost_cnt + 16'd1;
              end else begin
                dout <= din ^ FLIP;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              end
              if (mode_q == FM_ALT) cur_lost <= ~cur_lost;
            end
            if (!burst_inf && burst_rem == 8'd1) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              if (!burst_inf) burst_rem <= burst_rem - 8'd1;
              gap_cnt <= load_next;
              state   <= ST_GAP;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_hss_fault_sched.sv
module tb_pcs_hss_fault_sched;
  localparam int          DW   = 64;
  localparam int          CW   = 16;
  localparam logic [19:0] SEED = 20'h5A5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_gap;
  logic [CW-1:0] cfg_jmask;
  logic [7:0]    cfg_burst;
  logic          abort;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          done;
  logic [15:0]   err_cnt;
  logic [15:0]   lost_cnt;

  always #5 clk = ~clk;

  pcs_hss_fault_sched #(.DW(DW), .CW(CW), .LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .Rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_gap    (cfg_gap),
    .cfg_jmask  (cfg_jmask),
    .cfg_burst  (cfg_burst),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .lost_cnt   (lost_cnt)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is "clean words still to pass before the next
  // fault word", an event budget, and the fault type for the next event.
  logic          m_run, m_ready, m_alt_lost;
  logic [1:0]    m_mode;
  logic [15:0]   m_gap, m_jm, m_clean_left, m_err, m_lost;
  logic [7:0]    m_burst;
  logic [19:0]   m_lfsr;
  logic [DW-1:0] e_dout;
  logic          e_dv, e_done;

  // Observed-spacing tracking for the jitter run.
  logic [DW-1:0] last_din;
  logic          jit_on = 1'b0;
  int            obs_sp = 0;
  int            n_ev   = 0;

  function automatic logic [15:0] spacing(input logic [15:0] g, input logic [15:0] jm,
                                          input logic [19:0] l);
    logic [15:0] base;
    base = (g == 16'd0) ? 16'd1 : g;
    return base + (l[15:0] & jm);
  endfunction

  task automatic model_step();
    if (rst) begin
      m_run = 0; m_ready = 1; m_err = 0; m_lost = 0; m_lfsr = SEED;
      e_dout = '0; e_dv = 0; e_done = 0;
      return;
    end
    e_dout = din; e_dv = din_valid; e_done = 0;
    if (!m_run) begin
      if (cfg_valid && m_ready) begin
        m_mode = cfg_mode; m_gap = cfg_gap; m_jm = cfg_jmask; m_burst = cfg_burst;
        m_alt_lost = 0;
        m_clean_left = spacing(cfg_gap, cfg_jmask, m_lfsr);
        m_run = 1; m_ready = 0;
      end else begin
        m_ready = 1;
      end
    end else if (abort) begin
      m_run = 0; e_done = 1;
    end else if (din_valid) begin
      if (m_clean_left != 16'd0) begin
        m_clean_left = m_clean_left - 16'd1;
      end else begin
        if (m_mode != 2'b00) begin
          if (m_mode == 2'b10 || (m_mode == 2'b11 && m_alt_lost)) begin
            e_dout = '0;
            if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
          end else begin
            e_dout[DW-1] = ~e_dout[DW-1];
            e_dout[1]    = ~e_dout[1];
            e_dout[0]    = ~e_dout[0];
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          end
          if (m_mode == 2'b11) m_alt_lost = !m_alt_lost;
        end
        if (m_burst != 8'd0) begin
          m_burst = m_burst - 8'd1;
          if (m_burst == 8'd0) begin
            m_run = 0; e_done = 1;
          end
        end
        if (m_run) m_clean_left = spacing(m_gap, m_jm, m_lfsr);
      end
    end
    m_lfsr = {m_lfsr[18:0], m_lfsr[19] ^ m_lfsr[16]};
  endtask

  task automatic step();
    model_step();
    last_din = din;
    @(posedge clk);
    #1;
    chk("dout", dout, e_dout);
    chk("dout_valid", dout_valid, e_dv);
    chk("done", done, e_done);
    chk("busy", busy, m_run);
    chk("cfg_ready", cfg_ready, m_ready);
    chk("err_cnt", err_cnt, m_err);
    chk("lost_cnt", lost_cnt, m_lost);
    if (jit_on && dout_valid) begin
      if (dout !== last_din) begin
        chk("jit_space_in_4_7", (obs_sp >= 4 && obs_sp <= 7), 1);
        n_ev++;
        obs_sp = 0;
      end else begin
        obs_sp++;
      end
    end
  endtask

  task automatic word(input logic v);
    din = {$urandom, $urandom};
    din_valid = v;
    step();
  endtask

  task automatic configure(input logic [1:0] md, input logic [15:0] g,
                           input logic [15:0] jm, input logic [7:0] b);
    cfg_valid = 1; cfg_mode = md; cfg_gap = g; cfg_jmask = jm; cfg_burst = b;
    word(1);
    cfg_valid = 0;
  endtask

  initial begin
    int k;
    rst = 1; cfg_valid = 0; cfg_mode = 0; cfg_gap = 0; cfg_jmask = 0; cfg_burst = 0;
    abort = 0; din = '0; din_valid = 0;
    step();
    step();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_dout", dout, 0);
    rst = 0;

    // IDLE pass-through
    for (int i = 0; i < 10; i++) word(1);

    // bit error, gap 3, two events
    configure(2'b01, 16'd3, 16'd0, 8'd2);
    for (int i = 0; i < 12; i++) word(1);
    chk("biterr_err_cnt", err_cnt, 2);

    // alternate, gap 0, valid toggling
    configure(2'b11, 16'd0, 16'd0, 8'd4);
    for (int i = 0; i < 24; i++) word(i % 2 == 0);
    chk("alt_err_cnt", err_cnt, 4);
    chk("alt_lost_cnt", lost_cnt, 2);

    // lost words, unlimited, abort after two events
    configure(2'b10, 16'd5, 16'd0, 8'd0);
    k = 0;
    while (lost_cnt != 16'd4 && k < 60) begin
      word(1);
      k++;
    end
    chk("abort_reach", lost_cnt, 4);
    abort = 1;
    word(1);
    abort = 0;
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    chk("abort_lost", lost_cnt, 4);
    for (int i = 0; i < 10; i++) word(1);

    // jittered spacing
    configure(2'b01, 16'd4, 16'h0003, 8'd20);
    jit_on = 1; obs_sp = 0; n_ev = 0;
    k = 0;
    while (!done && k < 600) begin
      word($urandom_range(0, 3) != 0);
      k++;
    end
    jit_on = 0;
    chk("jit_done_seen", done, 1);
    chk("jit_events", n_ev, 20);
    chk("jit_err_cnt", err_cnt, 24);
    word(1);

    // reset in the middle of a run
    configure(2'b01, 16'd10, 16'd0, 8'd3);
    for (int i = 0; i < 4; i++) word(1);
    rst = 1;
    word(1);
    rst = 0;
    chk("midrst_dout", dout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_cnt, 0);
    chk("midrst_ready", cfg_ready, 1);
    for (int i = 0; i < 30; i++) word(1);
    chk("post_rst_err", err_cnt, 0);

    // randomized soak
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_gap   = 16'($urandom_range(0, 6));
      cfg_jmask = 16'($urandom_range(0, 7));
      cfg_burst = 8'($urandom_range(0, 5));
      abort     = ($urandom_range(0, 39) == 0);
      word($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
